// File: rtl/enc_pkg.sv
// Shared definitions for the 4-to-2 encoder and its downstream decoder stage.
// The code/one-hot types and the decode helper are reused by the encoder bench.
package enc_pkg;

  localparam int CODE_W    = 2;
  localparam int ONEHOT_W  = 4;
  localparam int NUM_CODES = 4;

  typedef logic [CODE_W-1:0]   code_t;
  typedef logic [ONEHOT_W-1:0] onehot_t;

  // Expand a 2-bit code into its one-hot word (1 << code).
  function automatic onehot_t code_to_onehot(input code_t code);
    onehot_t w_word;
    w_word = ONEHOT_W'(1) << code;
    return w_word;
  endfunction

endpackage

// File: rtl/code_decoder_stage_fifo.sv
// Small circular buffer holding encoder codes between the upstream handshake
// and the decode stage. Pointers wrap modulo DEPTH; occupancy is registered.
module code_fifo
  import enc_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = code_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  T                           i_wr_data,
  input  logic                       i_pop,
  output T                           o_rd_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_fill
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FILL_W = $clog2(DEPTH + 1);

  T                  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [FILL_W-1:0] r_fill;

  logic              w_full;
  logic              w_empty;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic [PTR_W-1:0]  w_wr_ptr_nxt;
  logic [PTR_W-1:0]  w_rd_ptr_nxt;

  assign w_full    = (r_fill == FILL_W'(DEPTH));
  assign w_empty   = (r_fill == FILL_W'(0));
  // Requests are qualified here too so a careless caller cannot corrupt the pointers.
  assign w_push_ok = i_push && !w_full;
  assign w_pop_ok  = i_pop  && !w_empty;

  // Next-pointer computation with explicit wrap at the last entry.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (r_wr_ptr == PTR_W'(DEPTH - 1)) begin
      w_wr_ptr_nxt = PTR_W'(0);
    end else begin
      w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
    end
    if (r_rd_ptr == PTR_W'(DEPTH - 1)) begin
      w_rd_ptr_nxt = PTR_W'(0);
    end else begin
      w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
    end
  end

  // Storage write; reset wipes every entry so nothing stale survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= T'(0);
      end
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves fill unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_fill   <= FILL_W'(0);
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_fill <= r_fill + FILL_W'(1);
        2'b01:   r_fill <= r_fill - FILL_W'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_fill    = r_fill;

endmodule

// File: rtl/code_decoder_stage.sv
// Decoder stage behind the 4-to-2 encoder: buffers incoming codes, presents
// them downstream as one-hot words and keeps saturating per-code pop counters.
module code_decoder_stage
  import enc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [CODE_W-1:0]          in_code,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [ONEHOT_W-1:0]        out_onehot,
  input  logic                       out_ready,
  input  logic                       clear_stats,
  input  logic [CODE_W-1:0]          stat_sel,
  output logic [CNT_W-1:0]           stat_count,
  output logic [$clog2(DEPTH+1)-1:0] fill
);

  localparam int FILL_W = $clog2(DEPTH + 1);

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_in_ready;
  logic              w_out_valid;
  code_t             w_rd_code;
  onehot_t           w_onehot;
  logic [FILL_W-1:0] w_fill;

  logic [CNT_W-1:0]  r_cnt [NUM_CODES];

  // in_ready is held low for as long as reset is asserted, even though the
  // FIFO itself already reads empty during reset.
  assign w_in_ready  = !w_full && reset;
  assign w_out_valid = !w_empty;
  assign w_push      = in_valid && w_in_ready;
  assign w_pop       = w_out_valid && out_ready;

  code_fifo #(
    .DEPTH (DEPTH),
    .T     (code_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .i_push    (w_push),
    .i_wr_data (in_code),
    .i_pop     (w_pop),
    .o_rd_data (w_rd_code),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_fill    (w_fill)
  );

  // Decode the head entry; the word reads zero whenever nothing is buffered.
  always_comb begin
    w_onehot = ONEHOT_W'(0);
    if (w_out_valid) begin
      w_onehot = code_to_onehot(w_rd_code);
    end else begin
      w_onehot = ONEHOT_W'(0);
    end
  end

  // Per-code consumption counters: clear beats a same-cycle pop, counts saturate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CODES; i++) begin
        r_cnt[i] <= CNT_W'(0);
      end
    end else if (clear_stats) begin
      for (int i = 0; i < NUM_CODES; i++) begin
        r_cnt[i] <= CNT_W'(0);
      end
    end else if (w_pop && (r_cnt[w_rd_code] != {CNT_W{1'b1}})) begin
      r_cnt[w_rd_code] <= r_cnt[w_rd_code] + CNT_W'(1);
    end else begin
      r_cnt[w_rd_code] <= r_cnt[w_rd_code];
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = w_out_valid;
  assign out_onehot = w_onehot;
  assign stat_count = r_cnt[stat_sel];
  assign fill       = w_fill;

endmodule

// File: tb/tb_code_decoder_stage.sv
// Scoreboard bench for code_decoder_stage: the driver queues hand-computed
// one-hot words on each accepted push, a negedge monitor pops and compares.
module tb_code_decoder_stage;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [1:0] in_code;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_onehot;
  logic       out_ready;
  logic       clear_stats;
  logic [1:0] stat_sel;
  logic [7:0] stat_count;
  logic [2:0] fill;

  int total;
  int bad;
  logic [3:0] exp_q[$];
  logic [3:0] wrap_code [4];
  logic [3:0] wrap_exp  [4];

  code_decoder_stage #(.DEPTH(4), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_code     (in_code),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_onehot  (out_onehot),
    .out_ready   (out_ready),
    .clear_stats (clear_stats),
    .stat_sel    (stat_sel),
    .stat_count  (stat_count),
    .fill        (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one code; queue its expected word once the stage can take it.
  task automatic push(input logic [1:0] c, input logic [3:0] e);
    in_valid = 1'b1;
    in_code  = c;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) break;
      tick();
    end
    total++;
    if (in_ready) begin
      exp_q.push_back(e);
      tick();
    end else begin
      bad++;
      $display("FAIL push_timeout: in_ready stayed %0b expected 1", in_ready);
    end
    in_valid = 1'b0;
  endtask

  // Monitor: every word the DUT hands over must match the queue head.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got %b expected no word", out_onehot);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (out_onehot !== e) begin
          bad++;
          $display("FAIL sb_word: got %b expected %b", out_onehot, e);
        end
      end
    end else if (reset && !out_valid) begin
      check("idle_onehot", {28'd0, out_onehot}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t expected earlier finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    wrap_code[0] = 4'd3; wrap_exp[0] = 4'b1000;
    wrap_code[1] = 4'd2; wrap_exp[1] = 4'b0100;
    wrap_code[2] = 4'd1; wrap_exp[2] = 4'b0010;
    wrap_code[3] = 4'd0; wrap_exp[3] = 4'b0001;

    reset       = 1'b0;
    in_valid    = 1'b1;
    in_code     = 2'd1;
    out_ready   = 1'b0;
    clear_stats = 1'b0;
    stat_sel    = 2'd0;

    // Reset held for 3 cycles with in_valid high
    repeat (3) tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_fill", {29'd0, fill}, 32'd0);
    check("rst_onehot", {28'd0, out_onehot}, 32'd0);
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("rel_fill", {29'd0, fill}, 32'd0);

    // Single transfer of code 2
    push(2'd2, 4'b0100);
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_onehot", {28'd0, out_onehot}, 32'b0100);
    check("single_fill", {29'd0, fill}, 32'd1);
    tick();
    check("single_hold", {28'd0, out_onehot}, 32'b0100);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    stat_sel  = 2'd2;
    #1;
    check("single_fill_after", {29'd0, fill}, 32'd0);
    check("single_stat2", {24'd0, stat_count}, 32'd1);

    // Fill to full, ignored fifth push, then drain
    push(2'd0, 4'b0001);
    push(2'd1, 4'b0010);
    push(2'd2, 4'b0100);
    push(2'd3, 4'b1000);
    check("full_fill", {29'd0, fill}, 32'd4);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_code  = 2'd1;
    tick();
    in_valid = 1'b0;
    check("full_ignored_fill", {29'd0, fill}, 32'd4);
    out_ready = 1'b1;
    tick();
    check("full_pop_not_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) tick();
    out_ready = 1'b0;
    check("drain_fill", {29'd0, fill}, 32'd0);
    check("drain_queue", exp_q.size(), 32'd0);

    // Simultaneous push and pop across pointer wrap
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_code = wrap_code[i % 4][1:0];
      total++;
      if (in_ready) begin
        exp_q.push_back(wrap_exp[i % 4]);
      end else begin
        bad++;
        $display("FAIL wrap_ready: got 0 expected 1");
      end
      tick();
      check("wrap_fill", {29'd0, fill}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("wrap_end_fill", {29'd0, fill}, 32'd0);

    // 300 pops of code 0 saturate its counter
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_code   = 2'd0;
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back(4'b0001);
      tick();
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    stat_sel = 2'd0; #1; check("sat_stat0", {24'd0, stat_count}, 32'd255);
    stat_sel = 2'd1; #1; check("stat1", {24'd0, stat_count}, 32'd3);
    stat_sel = 2'd2; #1; check("stat2", {24'd0, stat_count}, 32'd5);
    stat_sel = 2'd3; #1; check("stat3", {24'd0, stat_count}, 32'd4);

    // Clear collides with a pop of code 0: clear wins, FIFO still pops
    push(2'd0, 4'b0001);
    clear_stats = 1'b1;
    out_ready   = 1'b1;
    tick();
    clear_stats = 1'b0;
    out_ready   = 1'b0;
    stat_sel = 2'd0; #1;
    check("clear_stat0", {24'd0, stat_count}, 32'd0);
    check("clear_fill", {29'd0, fill}, 32'd0);
    stat_sel = 2'd2; #1;
    check("clear_stat2", {24'd0, stat_count}, 32'd0);

    // Rebuild some counts, then reset mid-operation with three buffered
    push(2'd3, 4'b1000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    stat_sel = 2'd3; #1;
    check("pre_rst_stat3", {24'd0, stat_count}, 32'd1);
    push(2'd1, 4'b0010);
    push(2'd2, 4'b0100);
    push(2'd3, 4'b1000);
    check("mid_fill", {29'd0, fill}, 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_fill", {29'd0, fill}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    exp_q.delete();
    #9;
    reset = 1'b1;
    #1;
    for (int s = 0; s < 4; s++) begin
      stat_sel = 2'(s);
      #1;
      check("post_rst_stat", {24'd0, stat_count}, 32'd0);
    end
    tick();
    check("post_rst_fill", {29'd0, fill}, 32'd0);
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    check("final_queue", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
